prs_conf_loader: RTL and testbench

PRS_CONF_LOADER -- requirements
Module: prs_conf_loader

---
 rtl/prs_conf_loader.sv | 134 +++++++++++++
 tb/tb_prs_conf_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prs_conf_loader.sv
// Program-stream configuration loader: unpacks 512-bit beats into eight 64-bit
// records, one per cycle, and issues action/CAM config writes.
module prs_conf_loader #(
  parameter int PROG_DATA_W     = 512,
  parameter int ACT_CONF_DATA_W = 32,
  parameter int ACT_CONF_ADDR_W = 10,
  parameter int CAM_CONF_DATA_W = 64,
  parameter int CAM_CONF_ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PROG_DATA_W-1:0]     prog_tdata,
  input  logic [PROG_DATA_W/8-1:0]   prog_tkeep,
  input  logic                       prog_tvalid,
  input  logic                       prog_tlast,
  output logic                       prog_tready,
  output logic                       act_conf_wr_en,
  output logic [ACT_CONF_ADDR_W-1:0] act_conf_addr,
  output logic [ACT_CONF_DATA_W-1:0] act_conf_data,
  output logic                       cam_conf_wr_en,
  output logic [CAM_CONF_ADDR_W-1:0] cam_conf_addr,
  output logic [CAM_CONF_DATA_W-1:0] cam_conf_data,
  output logic                       load_done,
  output logic [15:0]                err_cnt,
  output logic                       busy
);

  localparam int LANES = 8;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                      state_p0, state_nxt;
  logic [2:0]                  lane_p0;
  logic [PROG_DATA_W-1:0]      beat_p0;
  logic [LANES-1:0]            lane_ok_p0;
  logic                        last_p0;
  logic                        cam_pend_p0;
  logic [CAM_CONF_ADDR_W-1:0]  cam_addr_p0;

  logic [LANES-1:0] keep_lanes;
  logic             accept;
  logic             scan;
  logic [63:0]      lane_word;
  logic             lane_vld;
  logic [1:0]       rec_type;
  logic             act_hit, cam_hit, hdr_hit, rsv_hit;
  logic             pend_after, final_lane, orphan, err_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    keep_lanes = '0;
    for (int i = 0; i < LANES; i++) keep_lanes[i] = &prog_tkeep[8*i +: 8];
  end

  assign prog_tready = (state_p0 == IDLE);
  assign accept      = prog_tvalid && prog_tready;
  assign scan        = (state_p0 == SCAN);
  assign busy        = (state_p0 != IDLE) || cam_pend_p0;

  // Record decode for the lane under evaluation
  assign lane_word  = beat_p0[{lane_p0, 6'd0} +: 64];
  assign lane_vld   = scan && lane_ok_p0[lane_p0];
  assign rec_type   = lane_word[63:62];
  assign act_hit    = lane_vld && !cam_pend_p0 && (rec_type == 2'b01);
  assign hdr_hit    = lane_vld && !cam_pend_p0 && (rec_type == 2'b10);
  assign rsv_hit    = lane_vld && !cam_pend_p0 && (rec_type == 2'b11);
  assign cam_hit    = lane_vld && cam_pend_p0;
  assign pend_after = hdr_hit ? 1'b1 : (cam_hit ? 1'b0 : cam_pend_p0);
  assign final_lane = scan && (lane_p0 == 3'd7) && last_p0;
  // A header left without its data at the end of the image is malformed
  assign orphan     = final_lane && pend_after;
  assign err_inc    = rsv_hit || orphan;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (lane_p0 == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_nxt;
  end

  // Beat capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      beat_p0    <= prog_tdata;
      lane_ok_p0 <= keep_lanes;
      last_p0    <= prog_tlast;
    end
  end

  // Lane evaluation -> registered write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_p0        <= 3'd0;
      cam_pend_p0    <= 1'b0;
      cam_addr_p0    <= '0;
      act_conf_wr_en <= 1'b0;
      act_conf_addr  <= '0;
      act_conf_data  <= '0;
      cam_conf_wr_en <= 1'b0;
      cam_conf_addr  <= '0;
      cam_conf_data  <= '0;
      load_done      <= 1'b0;
      err_cnt        <= 16'd0;
    end else begin
      if (accept)    lane_p0 <= 3'd0;
      else if (scan) lane_p0 <= lane_p0 + 3'd1;
      cam_pend_p0    <= orphan ? 1'b0 : pend_after;
      if (hdr_hit) cam_addr_p0 <= lane_word[48 +: CAM_CONF_ADDR_W];
      act_conf_wr_en <= act_hit;
      if (act_hit) begin
        act_conf_addr <= lane_word[48 +: ACT_CONF_ADDR_W];
        act_conf_data <= lane_word[0 +: ACT_CONF_DATA_W];
      end
      cam_conf_wr_en <= cam_hit;
      if (cam_hit) begin
        cam_conf_addr <= cam_addr_p0;
        cam_conf_data <= lane_word[0 +: CAM_CONF_DATA_W];
      end
      load_done <= final_lane;
      if (err_inc) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_prs_conf_loader.sv
// Scoreboard bench for prs_conf_loader: a lane-level reference model queues the
// expected writes/done pulses (with their cycle) and a monitor pops them.
module tb_prs_conf_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] prog_tdata;
  logic [63:0]  prog_tkeep;
  logic         prog_tvalid;
  logic         prog_tlast;
  logic         prog_tready;
  logic         act_conf_wr_en;
  logic [9:0]   act_conf_addr;
  logic [31:0]  act_conf_data;
  logic         cam_conf_wr_en;
  logic [9:0]   cam_conf_addr;
  logic [63:0]  cam_conf_data;
  logic         load_done;
  logic [15:0]  err_cnt;
  logic         busy;

  prs_conf_loader dut (
    .clk(clk), .rst(rst),
    .prog_tdata(prog_tdata), .prog_tkeep(prog_tkeep),
    .prog_tvalid(prog_tvalid), .prog_tlast(prog_tlast), .prog_tready(prog_tready),
    .act_conf_wr_en(act_conf_wr_en), .act_conf_addr(act_conf_addr), .act_conf_data(act_conf_data),
    .cam_conf_wr_en(cam_conf_wr_en), .cam_conf_addr(cam_conf_addr), .cam_conf_data(cam_conf_data),
    .load_done(load_done), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 act write, 1 cam write, 2 load_done (data = err_cnt)
    logic [9:0]  addr;
    logic [63:0] data;
    longint      cyc;
  } ev_t;

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // Reference model state
  bit          m_pend = 0;
  logic [9:0]  m_paddr = '0;
  logic [15:0] m_err = '0;

  function automatic string kname(input int k);
    return (k == 0) ? "act_wr" : (k == 1) ? "cam_wr" : "load_done";
  endfunction

  task automatic push_ev(input int k, input logic [9:0] a, input logic [63:0] d, input longint c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [9:0] a, input logic [63:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got addr=%h data=%h at cycle %0d, expected nothing", kname(k), a, d, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.addr != a || e.data != d || e.cyc != cyc) begin
      errors++;
      $display("FAIL %s: got kind=%s addr=%h data=%h cycle=%0d, expected kind=%s addr=%h data=%h cycle=%0d",
               kname(e.kind), kname(k), a, d, cyc, kname(e.kind), e.addr, e.data, e.cyc);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: every presented output is matched against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (act_conf_wr_en) check_ev(0, act_conf_addr, {32'd0, act_conf_data});
        if (cam_conf_wr_en) check_ev(1, cam_conf_addr, cam_conf_data);
        if (load_done)      check_ev(2, 10'd0, {48'd0, err_cnt});
      end
    end
  end

  function automatic logic [15:0] sat1(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Record-level model: lane i of a beat accepted in cycle a shows up in cycle a+2+i
  task automatic model_beat(input logic [511:0] d, input logic [63:0] k, input bit l,
                            input longint a, input int nl);
    logic [63:0] w;
    for (int i = 0; i < nl; i++) begin
      w = d[i*64 +: 64];
      if (k[i*8 +: 8] != 8'hFF) continue;
      if (m_pend) begin
        push_ev(1, m_paddr, w, a + 2 + i);
        m_pend = 0;
      end else begin
        case (w[63:62])
          2'b01: push_ev(0, w[57:48], {32'd0, w[31:0]}, a + 2 + i);
          2'b10: begin m_pend = 1; m_paddr = w[57:48]; end
          2'b11: m_err = sat1(m_err);
          default: ;
        endcase
      end
    end
    if (nl == 8 && l) begin
      if (m_pend) begin m_err = sat1(m_err); m_pend = 0; end
      push_ev(2, 10'd0, {48'd0, m_err}, a + 9);
    end
  endtask

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input bit l, output longint a);
    int n;
    @(negedge clk);
    prog_tdata = d; prog_tkeep = k; prog_tlast = l; prog_tvalid = 1'b1;
    n = 0;
    while (!prog_tready && n < 50) begin @(negedge clk); n++; end
    if (!prog_tready) begin
      $display("FAIL handshake_timeout: prog_tready stayed 0 for %0d cycles, expected 1", n);
      $fatal(1, "handshake timeout");
    end
    a = cyc;
    @(posedge clk);
    #1 prog_tvalid = 1'b0;
  endtask

  task automatic send(input logic [511:0] d, input logic [63:0] k, input bit l);
    longint a;
    drive_beat(d, k, l, a);
    model_beat(d, k, l, a, 8);
  endtask

  function automatic logic [63:0] rec(input logic [1:0] t, input logic [9:0] ad, input logic [31:0] dt);
    return {t, 4'd0, ad, 16'd0, dt};
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  k;
    longint       a;
    int           n;

    rst = 1'b1; prog_tdata = '0; prog_tkeep = '0; prog_tvalid = 1'b0; prog_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_act_wr_en", {63'd0, act_conf_wr_en}, 64'd0);
    check_val("reset_cam_wr_en", {63'd0, cam_conf_wr_en}, 64'd0);
    check_val("reset_act_addr", {54'd0, act_conf_addr}, 64'd0);
    check_val("reset_cam_data", cam_conf_data, 64'd0);
    check_val("reset_load_done", {63'd0, load_done}, 64'd0);
    check_val("reset_err_cnt", {48'd0, err_cnt}, 64'd0);
    check_val("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    check_val("reset_tready", {63'd0, prog_tready}, 64'd1);

    // Single ACT record in lane 0 of a last beat
    d = '0;
    d[63:0] = rec(2'b01, 10'h005, 32'hDEADBEEF);
    send(d, '1, 1'b1);
    idle_cycles(12);
    check_val("act_single_err_cnt", {48'd0, err_cnt}, 64'd0);

    // CAM header in lane 7, data in lane 0 of the next beat
    d = '0;
    d[511:448] = rec(2'b10, 10'h3FF, 32'h0);
    send(d, '1, 1'b0);
    n = 0;
    while (!prog_tready && n < 20) begin @(negedge clk); n++; end
    check_val("busy_between_beats", {63'd0, busy}, 64'd1);
    d = '0;
    d[63:0] = 64'h0123456789ABCDEF;
    send(d, '1, 1'b1);
    idle_cycles(12);

    // Orphan header at the end of the image
    d = '0;
    d[511:448] = rec(2'b10, 10'h155, 32'h0);
    send(d, '1, 1'b1);
    idle_cycles(12);
    check_val("orphan_err_cnt", {48'd0, err_cnt}, {48'd0, m_err});

    // Only odd lanes carry valid bytes
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = rec(2'b01, 10'(i * 3 + 1), 32'hA0000000 + i);
    send(d, 64'hFF00_FF00_FF00_FF00, 1'b1);
    idle_cycles(12);

    // Randomized stream
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < 8; i++) begin
        d[i*64 +: 64] = {$urandom, $urandom};
        k[i*8 +: 8] = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      send(d, k, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 4));
    end
    idle_cycles(12);
    check_val("random_err_cnt", {48'd0, err_cnt}, {48'd0, m_err});

    // Reset while lane 3 of an all-ACT beat is being evaluated
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = rec(2'b01, 10'(32 + i), 32'h5EED0000 + i);
    drive_beat(d, '1, 1'b0, a);
    model_beat(d, '1, 1'b0, a, 3);
    while (cyc < a + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_scan_act_wr_en", {63'd0, act_conf_wr_en}, 64'd0);
    check_val("rst_scan_act_addr", {54'd0, act_conf_addr}, 64'd0);
    check_val("rst_scan_act_data", {32'd0, act_conf_data}, 64'd0);
    check_val("rst_scan_busy", {63'd0, busy}, 64'd0);
    check_val("rst_scan_err_cnt", {48'd0, err_cnt}, 64'd0);
    check_val("rst_scan_pending", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    m_pend = 0; m_err = '0;
    @(negedge clk);
    check_val("rst_scan_tready", {63'd0, prog_tready}, 64'd1);
    idle_cycles(12);

    // Reserved records everywhere: error counter must saturate
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = rec(2'b11, 10'(i), 32'(i));
    for (int b = 0; b < 8192; b++) send(d, '1, (b == 8191));
    idle_cycles(12);
    check_val("err_cnt_saturated", {48'd0, err_cnt}, 64'h000000000000FFFF);

    check_val("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
